// File: rtl/round_robin_arbiter_locked.sv
// Locking round-robin arbiter: a grant is held for a whole transaction and
// priority rotates past the owner on release. Define RR_ARB_TIMEOUT_EN to cap grants at MAX_HOLD cycles.
module round_robin_arbiter_locked #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         requests,
    input  logic [N-1:0]         last,
    output logic [N-1:0]         grants,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 dbg_busy,
    output logic [$clog2(N)-1:0] dbg_ptr
);

    localparam int IW = $clog2(N);

    if (N < 2) begin : g_bad_n
        $error("round_robin_arbiter_locked: N must be >= 2");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("round_robin_arbiter_locked: MAX_HOLD must be >= 1");
    end

    typedef enum logic {IDLE, BUSY} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] start;
    logic [IW-1:0] after_owner;
    logic [IW:0]   hit;
    logic          release_now;
    logic          timeout;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (int'(i) == N - 1) return '0;
        return i + IW'(1);
    endfunction

    // First asserted request scanning start, start+1, ... modulo N; MSB = found.
    function automatic logic [IW:0] search(input logic [IW-1:0] s, input logic [N-1:0] req);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(s) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx]) res = {1'b1, IW'(idx)};
        end
        return res;
    endfunction

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    assign timeout = (cnt_q == CW'(MAX_HOLD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // Counter restarts on every new grant, including a back-to-back handover.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == BUSY) begin
            if (release_now) cnt_d = '0;
            else             cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign after_owner = next_idx(owner_q);
    // After a release the owner is naturally the last candidate of the scan.
    assign start       = (state_q == BUSY) ? after_owner : ptr_q;
    assign hit         = search(start, requests);
    assign release_now = (state_q == BUSY) &&
                         (!requests[owner_q] || last[owner_q] || timeout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (hit[IW]) begin
                    state_d = BUSY;
                    owner_d = hit[IW-1:0];
                end
            end
            BUSY: begin
                if (release_now) begin
                    ptr_d = after_owner;
                    if (hit[IW]) begin
                        owner_d = hit[IW-1:0];
                    end else begin
                        state_d = IDLE;
                        owner_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
            end
        endcase
    end

    // Outputs decode only flops, so nothing here depends on the inputs.
    always_comb begin
        grants = '0;
        if (state_q == BUSY) grants[owner_q] = 1'b1;
        grant_valid = (state_q == BUSY);
        grant_id    = owner_q;
        dbg_busy    = (state_q == BUSY);
        dbg_ptr     = ptr_q;
    end

endmodule

// File: tb/tb_round_robin_arbiter_locked.sv
// Directed bench for round_robin_arbiter_locked with N=4, MAX_HOLD=4;
// expectations follow the RR_ARB_TIMEOUT_EN setting of the build.
module tb_round_robin_arbiter_locked;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  requests = '0;
    logic [N-1:0]  last = '0;
    logic [N-1:0]  grants;
    logic          grant_valid;
    logic [IW-1:0] grant_id;
    logic          dbg_busy;
    logic [IW-1:0] dbg_ptr;

    int total = 0;
    int bad   = 0;

    round_robin_arbiter_locked #(.N(N), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .requests(requests), .last(last),
        .grants(grants), .grant_valid(grant_valid), .grant_id(grant_id),
        .dbg_busy(dbg_busy), .dbg_ptr(dbg_ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input logic [N-1:0] exp);
        logic [IW-1:0] id;
        id = '0;
        for (int i = 0; i < N; i++) if (exp[i]) id = IW'(i);
        chk({tag, ".grants"}, 32'(grants), 32'(exp));
        chk({tag, ".valid"}, 32'(grant_valid), 32'(|exp));
        chk({tag, ".id"}, 32'(grant_id), 32'(id));
        chk({tag, ".busy"}, 32'(dbg_busy), 32'(|exp));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        requests = '0;
        last = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] exp;

        // Reset state and single requester grant/abandon.
        do_reset();
        expect_grant("rst", 4'b0000);
        chk("rst.ptr", 32'(dbg_ptr), 0);
        requests = 4'b0001;
        step();
        expect_grant("s1.grant", 4'b0001);
        step();
        expect_grant("s1.hold", 4'b0001);
        requests = 4'b0000;
        last = 4'b0001;
        step();
        expect_grant("s1.idle", 4'b0000);
        chk("s1.ptr", 32'(dbg_ptr), 1);
        last = '0;

        // All requesting, each owner ends on its second cycle.
        do_reset();
        requests = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) begin
            exp = 4'b0001 << (i % N);
            last = '0;
            expect_grant($sformatf("s2.c1_%0d", i), exp);
            step();
            expect_grant($sformatf("s2.c2_%0d", i), exp);
            last = exp;
            step();
        end
        expect_grant("s2.after", 4'b0010);
        last = '0;

        // Owner never signals last.
        do_reset();
        requests = 4'b0101;
        step();
`ifdef RR_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            expect_grant($sformatf("s3.a%0d", i), 4'b0001);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            expect_grant($sformatf("s3.b%0d", i), 4'b0100);
            step();
        end
        expect_grant("s3.c", 4'b0001);
`else
        for (int i = 0; i < 22; i++) begin
            expect_grant($sformatf("s3.hold%0d", i), 4'b0001);
            step();
        end
`endif

        // Lone requester with last every cycle keeps the grant with no bubble.
        do_reset();
        requests = 4'b0100;
        last = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            step();
            expect_grant($sformatf("s4.%0d", i), 4'b0100);
        end
        last = '0;

        // Owner 1 abandons while 3 waits.
        do_reset();
        requests = 4'b1010;
        step();
        expect_grant("s5.own1", 4'b0010);
        requests = 4'b1000;
        step();
        expect_grant("s5.own3", 4'b1000);
        chk("s5.ptr", 32'(dbg_ptr), 2);
        // Owner 1 released into idle, then pointer 2 favours requester 2 over 1.
        do_reset();
        requests = 4'b0010;
        step();
        expect_grant("s5b.own1", 4'b0010);
        requests = 4'b0000;
        step();
        expect_grant("s5b.idle", 4'b0000);
        chk("s5b.ptr", 32'(dbg_ptr), 2);
        requests = 4'b0110;
        step();
        expect_grant("s5b.own2", 4'b0100);

        // Asynchronous reset mid-grant.
        do_reset();
        requests = 4'b0100;
        step();
        expect_grant("s6.own2", 4'b0100);
        #2 rst = 1'b1;
        #1;
        expect_grant("s6.async", 4'b0000);
        chk("s6.ptr", 32'(dbg_ptr), 0);
        rst = 1'b0;
        requests = 4'b1010;
        step();
        expect_grant("s6.post", 4'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/round_robin_arbiter_locked.md
# round_robin_arbiter_locked

Locking round-robin arbiter sharing one multi-cycle resource (bus port, memory bank, shared ALU) among `N` requesters. Unlike a per-cycle arbiter, a grant is held by its owner for a whole transaction until the owner signals its final beat or withdraws. Priority then rotates to the requester after the owner. Sits between requester front-ends and the resource mux, driving its select lines.

## Interface
- `N`, default 4: number of requesters, ≥2.
- `MAX_HOLD`, default 8: maximum grant length in cycles, ≥1. Used only with `RR_ARB_TIMEOUT_EN`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `requests` input N: per-requester request, level; held high for the whole transaction.
- `last` input N: per-requester final-beat flag; meaningful only for the current owner while its request is high.
- `grants` output N: registered one-hot grant, or all-zero.
- `grant_valid` output 1: registered; equals `|grants`.
- `grant_id` output $clog2(N): registered index of the owner; 0 when idle.

## Operation
- State: `IDLE` (no owner) or `BUSY` (owner = `grant_id`). Also holds a priority pointer `ptr`; with the timeout macro, it also holds the hold counter `cnt`.
- Winner search: first asserted `requests` bit scanning `ptr`, `ptr+1`, … with wrap modulo N.
- `IDLE`, any request: winner granted at next edge → `BUSY`. With no request, stay in `IDLE`.
- `BUSY` release condition, evaluated each cycle on the owner `o`:
  - `requests[o] & last[o]` (transfer complete), or
  - `!requests[o]` (abandon), or
  - timeout (macro only).
- `BUSY`, no release: `grants` unchanged, whatever other requests do.
- `BUSY`, release: `ptr` ← `(o+1) mod N`.
  - At the same edge, search the current `requests` from `(o+1) mod N`. The owner is eligible only as the last candidate, and only if its request is still high.
  - A hit grants the winner with no bubble cycle. No hit → `IDLE`, outputs zero.
- `ptr` changes only on release. Reset value is 0.
- Non-owner `last` bits are ignored. Owner `last` with its request low counts as abandon.
- Exactly one bit of `grants` is high in `BUSY`. `grant_id` is always consistent with `grants`.

## Timing
- Reset (asynchronous, takes effect immediately): `grants`=0, `grant_valid`=0, `grant_id`=0, `ptr`=0, `cnt`=0, state `IDLE`. Reset mid-grant drops the grant at once. The first grant after reset scans from index 0.
- Grant latency: a request sampled at edge k in `IDLE` produces `grants` high after edge k.
- Release latency: release condition sampled at edge k. The owner's grant is low after edge k, and the next owner's grant is high after the same edge.
- Minimum grant length is 1 cycle: `last` high in the first granted cycle releases at the following edge.
- Requests arriving during `BUSY` wait. The wait is bounded only by owners' transaction lengths; with the macro, it is bounded by `(N-1)*MAX_HOLD` cycles.
- Outputs never depend combinationally on inputs.

## Configuration
- Macro `RR_ARB_TIMEOUT_EN`.
- Defined:
  - `cnt` (width $clog2(MAX_HOLD+1)) clears on each new grant and increments every `BUSY` cycle.
  - When `cnt == MAX_HOLD-1` and no other release condition holds, a forced release occurs at that edge. Total grant length is capped at `MAX_HOLD` cycles.
  - A forced release rotates `ptr` exactly like a normal release.
- Not defined: no counter. The owner holds the grant until `last` or abandon, possibly forever.

## Test plan
All scenarios use N=4 and MAX_HOLD=4.
- Reset, then `requests`=0001 from cycle 1 → `grants`=0001 and `grant_id`=0 from cycle 2. `last[0]` pulse releases; with no other request, `grants`=0000 next cycle.
- `requests`=1111 held, owner pulses `last` in its 2nd granted cycle → grant sequence 0001, 0010, 0100, 1000, 0001, each held exactly 2 cycles, no idle cycles.
- `requests`=0101, owner 0 never asserts `last` → without macro, `grants`=0001 for 20+ cycles. With `RR_ARB_TIMEOUT_EN`, `grants`=0001 for 4 cycles, then 0100 for 4, then 0001.
- Only `requests`=0100, `last[2]` high every cycle → `grants`=0100 continuously, `grant_valid` never drops, no bubble.
- Owner 1 drops its request without `last` while `requests[3]`=1 → `grants`=1000 at the next edge, and `ptr`=2 afterwards. Verify a later `requests`=0110 yields `grants`=0100.
- `rst` pulsed asynchronously mid-grant with `grants`=0100 → outputs 0 before the next clock edge. After release of reset with `requests`=1010, `grants`=0010.
